// File: rtl/case_5_sdiv_pkg.sv
// Shared constants and FSM encoding for the sequential signed divider.
package case_5_sdiv_pkg;

  localparam int DIN0_W = 11;  // dividend / quotient magnitude width
  localparam int DIN1_W = 4;   // divisor / remainder width
  localparam int DOUT_W = 11;  // quotient width
  localparam int CNT_W  = 4;   // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/case_5_udiv_step.sv
// One restoring-division step: shift in the next dividend bit, compare
// against the divisor magnitude, subtract when it fits.
import case_5_sdiv_pkg::*;

module case_5_udiv_step #(
  parameter int W = DIN1_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Partial remainder stays below the divisor, so W bits always hold it
  // after the step; the extra bit only matters for the compare.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = (shifted >= {1'b0, dvs_i});
    rem_o   = W'(q_o ? diff : shifted);
  end

endmodule

// File: rtl/case_5_sdiv_11s_4s_11_seq.sv
// Sequential signed divider (truncating semantics): magnitudes are divided
// MSB-first with a restoring step per enabled cycle, signs fixed at the end.
import case_5_sdiv_pkg::*;

module case_5_sdiv_11s_4s_11_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(din0_WIDTH - 1);

  // ID is informational only; a negative value is simply meaningless.
  if (ID < 0) begin : g_id_unused
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [din0_WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, becomes quotient
  logic [din1_WIDTH-1:0]   acc_q, acc_d;     // partial remainder
  logic [din1_WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [din1_WIDTH-1:0]   lo_q, lo_d;       // raw low dividend bits for divide-by-zero
  logic                    s0_q, s0_d;
  logic                    s1_q, s1_d;
  logic                    dz_q, dz_d;
  logic                    done_q, done_d;
  logic [dout_WIDTH-1:0]   dout_q, dout_d;
  logic [din1_WIDTH-1:0]   rem_q, rem_d;

  logic [din1_WIDTH-1:0]   step_rem;
  logic                    step_q;
  logic [din0_WIDTH-1:0]   quo_s;
  logic [din1_WIDTH-1:0]   rem_s;

  case_5_udiv_step #(.W(din1_WIDTH)) u_step (
    .rem_i (acc_q),
    .bit_i (dvd_q[din0_WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state, datapath and result computation; ce gating lives in the flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    rem_d   = rem_q;
    quo_s   = s0_q ^ s1_q ? -dvd_q : dvd_q;
    rem_s   = s0_q ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          // -MIN wraps to itself, which read unsigned is the right magnitude
          dvd_d   = din0[din0_WIDTH-1] ? -din0 : din0;
          dvs_d   = din1[din1_WIDTH-1] ? -din1 : din1;
          acc_d   = '0;
          s0_d    = din0[din0_WIDTH-1];
          s1_d    = din1[din1_WIDTH-1];
          dz_d    = (din1 == '0);
          lo_d    = din0[din1_WIDTH-1:0];
        end
      end
      CALC: begin
        dvd_d = {dvd_q[din0_WIDTH-2:0], step_q};
        acc_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          dout_d = '1;
          rem_d  = lo_q;
        end else begin
          dout_d = dout_WIDTH'(quo_s);
          rem_d  = rem_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers: sync reset wins over ce, ce low freezes all.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      lo_q    <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign dout  = dout_q;
  assign rem   = rem_q;

endmodule

// File: tb/tb_case_5_sdiv_11s_4s_11_seq.sv
// Directed bench for the sequential signed divider with a latency/arith model.
module tb_case_5_sdiv_11s_4s_11_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n, ce, start;
  logic [10:0] din0;
  logic [3:0]  din1;
  logic        ready, done;
  logic [10:0] dout;
  logic [3:0]  rem;

  int n_pass = 0, n_total = 0;
  logic chk_en = 1'b0;

  case_5_sdiv_11s_4s_11_seq #(.ID(1), .din0_WIDTH(11), .din1_WIDTH(4), .dout_WIDTH(11)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .ready(ready), .done(done), .dout(dout), .rem(rem)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // C-style truncating division on plain integers
  function automatic logic [10:0] f_q(int a, int b);
    int q;
    if (b == 0) return 11'h7FF;
    q = a / b;
    return q[10:0];
  endfunction

  function automatic logic [3:0] f_r(int a, int b);
    int r;
    if (b == 0) return a[3:0];
    r = a % b;
    return r[3:0];
  endfunction

  // Model: busy for 12 enabled cycles after an accepted start, then a result.
  int         m_a, m_b, m_left;
  logic       m_busy, m_done;
  logic [10:0] m_dout;
  logic [3:0]  m_rem;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_busy <= 1'b0; m_left <= 0; m_done <= 1'b0; m_dout <= '0; m_rem <= '0;
    end else if (ce) begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dout <= f_q(m_a, m_b);
          m_rem  <= f_r(m_a, m_b);
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= 12;
        m_a    <= $signed(din0);
        m_b    <= $signed(din1);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("cyc_done",  {31'd0, done},  {31'd0, m_done});
      chk("cyc_ready", {31'd0, ready}, {31'd0, !m_busy});
      chk("cyc_dout",  {21'd0, dout},  {21'd0, m_dout});
      chk("cyc_rem",   {28'd0, rem},   {28'd0, m_rem});
    end
  end

  // Start a division; optional 3-cycle ce stall after cycle stall_at (>0),
  // optional extra start pulse at cycle sp (>0). Checks latency and results.
  task automatic run_div(input logic [10:0] a, input logic [3:0] b,
                         input logic [10:0] eq, input logic [3:0] er,
                         input int lat, input int stall_at, input int sp, input string nm);
    int got;
    din0 = a; din1 = b; start = 1'b1; ce = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    got = -1;
    for (int c = 1; c <= 40; c++) begin
      ce = (stall_at > 0 && c > stall_at && c <= stall_at + 3) ? 1'b0 : 1'b1;
      if (sp > 0 && c == sp) begin start = 1'b1; din0 = 11'd1; din1 = 4'd1; end
      else start = 1'b0;
      @(negedge ap_clk);
      if (done) begin got = c; break; end
    end
    start = 1'b0; ce = 1'b1;
    if (got < 0) $display("FAIL %s_timeout: no done within 40 cycles", nm);
    chk({nm, "_lat"},  got, lat);
    chk({nm, "_dout"}, {21'd0, dout}, {21'd0, eq});
    chk({nm, "_rem"},  {28'd0, rem},  {28'd0, er});
  endtask

  initial begin
    int seen;
    ap_rst_n = 1'b0; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge ap_clk);
    chk_en = 1'b1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_dout",  {21'd0, dout},  32'd0);
    chk("rst_rem",   {28'd0, rem},   32'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    run_div(11'd100,   4'd7,   11'h00E, 4'h2, 12, 0, 0, "p100_7");
    run_div(-11'sd100, 4'd7,   11'h7F2, 4'hE, 12, 0, 0, "m100_7");
    run_div(11'h400,   4'hF,   11'h400, 4'h0, 12, 0, 0, "ovf");
    run_div(11'd5,     4'd0,   11'h7FF, 4'h5, 12, 0, 0, "dz");
    run_div(11'd100,   4'd7,   11'h00E, 4'h2, 15, 4, 0, "stall");
    // start during FIX must not launch a new division
    run_div(11'd33,    4'hD,   11'h7F5, 4'h0, 12, 0, 12, "fixstart");
    repeat (14) @(negedge ap_clk);

    // Mid-CALC start ignored, then reset (with ce low) aborts without done
    din0 = 11'd100; din1 = 4'd7; start = 1'b1;
    @(negedge ap_clk);
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin start = 1'b1; din0 = 11'd1; din1 = 4'd1; end
      else start = 1'b0;
      if (c == 6) begin ap_rst_n = 1'b0; ce = 1'b0; end
      else begin ap_rst_n = 1'b1; ce = 1'b1; end
      @(negedge ap_clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_ready", {31'd0, ready}, 32'd1);

    run_div(-11'sd7,   4'h8,   11'h000, 4'h9, 12, 0, 0, "m7_m8");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/case_5_sdiv_11s_4s_11_seq.md
CASE_5_SDIV_11S_4S_11_SEQ -- requirements
Module: case_5_sdiv_11s_4s_11_seq

Interface
REQ-001 The module SHALL have parameter ID, default 1, instance identifier with no functional effect.
REQ-002 The module SHALL have parameter din0_WIDTH, default 11, dividend width.
REQ-003 The module SHALL have parameter din1_WIDTH, default 4, divisor and remainder width.
REQ-004 The module SHALL have parameter dout_WIDTH, default 11, quotient width.
REQ-005 The module SHALL have port ap_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port ap_rst_n, input, 1, synchronous active-low reset.
REQ-007 The module SHALL have port ce, input, 1, clock enable; when low, all state holds.
REQ-008 The module SHALL have port start, input, 1, request to begin a division.
REQ-009 The module SHALL have port din0, input, din0_WIDTH, signed dividend.
REQ-010 The module SHALL have port din1, input, din1_WIDTH, signed divisor.
REQ-011 The module SHALL have port ready, output, 1, high when in IDLE and a start will be accepted.
REQ-012 The module SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-013 The module SHALL have port dout, output, dout_WIDTH, signed quotient.
REQ-014 The module SHALL have port rem, output, din1_WIDTH, signed remainder.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC and FIX.
- IDLE -> CALC on start && ce.
- CALC -> FIX after din0_WIDTH iterations.
- FIX -> IDLE unconditionally, on a ce cycle.
REQ-016 On accept, the module SHALL register |din0| (unsigned, din0_WIDTH bits, so -1024 gives 1024), |din1|, both sign bits and a divide-by-zero flag.
REQ-017 CALC SHALL perform one restoring shift-subtract step per ce cycle, MSB first, using a 4-bit iteration counter.
REQ-018 FIX SHALL apply sign correction and update dout and rem.
- Quotient sign = sign(din0) XOR sign(din1).
- Remainder sign = sign(din0), giving truncating (C) semantics.
REQ-019 With ce held high, done SHALL be high exactly din0_WIDTH+1 = 12 cycles after the accepting edge, for one cycle.
REQ-020 dout and rem SHALL hold their values until the next done.
REQ-021 ce low SHALL freeze the state, counter, datapath and done, extending latency by the number of stalled cycles.
REQ-022 start while not in IDLE SHALL be ignored, with no effect on the current operation.
REQ-023 start in the same cycle as a FIX->IDLE transition SHALL be ignored, because ready is low in FIX.
REQ-024 Divide by zero SHALL complete with normal latency, giving dout = all ones and rem = din0[din1_WIDTH-1:0].
REQ-025 Overflow (-1024 / -1) SHALL produce quotient 11'h400 (wrapped) and rem = 0.
REQ-026 ready SHALL equal (state == IDLE), combinationally from the state register.

Reset
REQ-027 The reset SHALL be synchronous and active-low: ap_rst_n low at a rising edge of ap_clk takes effect on that edge, independent of ce.
REQ-028 Reset SHALL force state = IDLE, done = 0, dout = 0, rem = 0 and counter = 0; ready is 1 after reset.
REQ-029 Reset mid-operation SHALL abort the division, with no done pulse for the aborted operation.

Structure
REQ-030 Package case_5_sdiv_pkg SHALL hold the state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2) and the default width constants.
REQ-031 The module SHALL instantiate a single combinational sub-module, case_5_udiv_step, computing one partial-remainder compare, subtract and quotient bit; the FSM and registers SHALL stay in the top module.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- 100 / 7 -> dout=14 (11'h00E), rem=2; done 12 cycles after start.
- -100 / 7 -> dout=11'h7F2 (-14), rem=4'hE (-2).
- -1024 / -1 -> dout=11'h400, rem=0.
- 5 / 0 -> dout=11'h7FF, rem=4'h5.
- 100 / 7 with ce low for 3 cycles mid-CALC -> done at cycle 15, same results.
- start pulsed mid-CALC is ignored, and reset at cycle 6 gives no done; subsequently -7 / -8 -> dout=0, rem=4'h9 (-7).
